// File: rtl/bpsk_modulator.sv
// BPSK modulator: DDS carrier (phase accumulator + sine ROM) sign-flipped per chip, gated to a
// burst window opened by i_sinc. Define BPSK_RAMP_EN to add a linear attack/decay envelope.
module bpsk_modulator #(
  parameter int NB_REG      = 32,
  parameter int NB_CODE     = 8,
  parameter int NB_LUT_ADDR = 8,
  parameter int NB_DAC      = 14,
  parameter int RAMP_LEN    = 256
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_sinc,
  input  logic [NB_REG-1:0]  i_period,
  input  logic [NB_REG-1:0]  i_fcw,
  input  logic [NB_CODE-1:0] i_code,
  output logic [NB_DAC-1:0]  o_dac,
  output logic               o_active
);

  localparam int LUT_DEPTH = 1 << NB_LUT_ADDR;
  localparam logic signed [NB_DAC-1:0] DAC_MIN = {1'b1, {(NB_DAC-1){1'b0}}};
  localparam logic signed [NB_DAC-1:0] DAC_MAX = {1'b0, {(NB_DAC-1){1'b1}}};

  // Full-wave sine table built at elaboration from Bhaskara's approximation; exact zeros at
  // 0 and pi and exact +/- full scale at pi/2 and 3pi/2, so the fs/4 tone hits the rails.
  function automatic logic signed [NB_DAC-1:0] sine_sample(input int idx);
    longint half, h, amp, num, den, mag;
    half = longint'(1) << (NB_LUT_ADDR - 1);
    h    = longint'(idx) % half;
    amp  = (longint'(1) << (NB_DAC - 1)) - 1;
    num  = 16 * h * (half - h);
    den  = 5 * half * half - 4 * h * (half - h);
    mag  = (amp * num) / den;
    if (longint'(idx) >= half) mag = -mag;
    return NB_DAC'(mag);
  endfunction

  logic signed [NB_DAC-1:0] rom [LUT_DEPTH];
  for (genvar g = 0; g < LUT_DEPTH; g++) begin : g_rom
    assign rom[g] = sine_sample(g);
  end

  logic [NB_REG-1:0] win_cnt, acc, fcw_q;
  logic [NB_REG-1:0] rem, cur_phase, cur_fcw;
  logic              win_open;

  // The i_sinc cycle is itself the first window clock, so a new pulse overrides the running burst.
  assign rem       = i_sinc ? i_period : win_cnt;
  assign win_open  = (rem != '0);
  assign cur_phase = i_sinc ? '0 : acc;
  assign cur_fcw   = i_sinc ? i_fcw : fcw_q;

  logic unused_code;
  assign unused_code = ^i_code[NB_CODE-1:1];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      win_cnt <= '0;
      acc     <= '0;
      fcw_q   <= '0;
    end else begin
      if (i_sinc) fcw_q <= i_fcw;
      win_cnt <= win_open ? rem - NB_REG'(1) : '0;
      acc     <= win_open ? cur_phase + cur_fcw : cur_phase;
    end
  end

  logic [NB_LUT_ADDR-1:0]   addr_s1;
  logic                     chip_s1, open_s1;
  logic signed [NB_DAC-1:0] rom_s2;
  logic                     chip_s2, open_s2;
  logic signed [NB_DAC-1:0] s3;
  logic                     open_s3;
  logic signed [NB_DAC-1:0] s4;
  logic                     open_s4;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr_s1 <= '0;
      chip_s1 <= 1'b0;
      open_s1 <= 1'b0;
      rom_s2  <= '0;
      chip_s2 <= 1'b0;
      open_s2 <= 1'b0;
      s3      <= '0;
      open_s3 <= 1'b0;
      open_s4 <= 1'b0;
    end else begin
      addr_s1 <= cur_phase[NB_REG-1 -: NB_LUT_ADDR];
      chip_s1 <= i_code[0];
      open_s1 <= win_open;
      rom_s2  <= rom[addr_s1];
      chip_s2 <= chip_s1;
      open_s2 <= open_s1;
      open_s3 <= open_s2;
      open_s4 <= open_s3;
      // Negating the most negative code would wrap, so it saturates to the positive rail.
      if (!open_s2)             s3 <= '0;
      else if (chip_s2)         s3 <= rom_s2;
      else if (rom_s2 == DAC_MIN) s3 <= DAC_MAX;
      else                      s3 <= -rom_s2;
    end
  end

`ifdef BPSK_RAMP_EN
  localparam int ENV_W = $clog2(RAMP_LEN + 1);
  localparam int SHIFT = $clog2(RAMP_LEN);
  localparam int PW    = NB_DAC + ENV_W + 1;

  logic [ENV_W-1:0] env, env_base, env_cur, env_s1, env_s2, env_s3;
  logic signed [PW-1:0] prod, scaled;

  // Envelope climbs while more than RAMP_LEN window clocks remain, then decays to zero by the end.
  always_comb begin
    env_base = i_sinc ? '0 : env;
    env_cur  = env_base;
    if (win_open && (rem > NB_REG'(RAMP_LEN))) begin
      if (env_base != ENV_W'(RAMP_LEN)) env_cur = env_base + ENV_W'(1);
    end else if (env_base != '0) begin
      env_cur = env_base - ENV_W'(1);
    end
  end

  assign prod   = PW'(s3) * PW'($signed({1'b0, env_s3}));
  assign scaled = prod >>> SHIFT;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      env    <= '0;
      env_s1 <= '0;
      env_s2 <= '0;
      env_s3 <= '0;
      s4     <= '0;
    end else begin
      env    <= env_cur;
      env_s1 <= env_cur;
      env_s2 <= env_s1;
      env_s3 <= env_s2;
      s4     <= scaled[NB_DAC-1:0];
    end
  end
`else
  logic [31:0] unused_ramp_len;
  assign unused_ramp_len = 32'(RAMP_LEN);

  always_ff @(posedge i_clk) begin
    if (i_rst) s4 <= '0;
    else       s4 <= s3;
  end
`endif

  assign o_dac    = {~s4[NB_DAC-1], s4[NB_DAC-2:0]};
  assign o_active = open_s4;

endmodule
